// File: rtl/qfix_pkg.sv
// Shared constants and FSM state encoding for the Q15.16 signed-magnitude
// arithmetic blocks (multiplier and sequential divider).
package qfix_pkg;

    localparam int unsigned QW       = 32;
    localparam int unsigned QFRAC    = 16;
    localparam int unsigned QSIGN    = QW - 1;
    localparam logic [QW-2:0] QMAG_MAX = 31'h7FFFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } qstate_e;

endpackage

// File: rtl/udiv_step.sv
// One combinational restoring-division step: shift in the next numerator bit,
// subtract the divisor when it fits, and report the quotient bit.
module udiv_step #(
    parameter int unsigned MAGW = 31
) (
    input  logic [MAGW:0]   rem,
    input  logic            num_bit,
    input  logic [MAGW-1:0] mag_d,
    output logic [MAGW:0]   rem_next,
    output logic            qbit
);

    logic [MAGW:0] shifted;

    // A set top bit means the shifted value exceeds any divisor; the
    // modular subtraction still yields the correct remainder.
    always_comb begin
        shifted  = {rem[MAGW-1:0], num_bit};
        qbit     = rem[MAGW] || (shifted >= {1'b0, mag_d});
        rem_next = qbit ? (shifted - {1'b0, mag_d}) : shifted;
    end

endmodule

// File: rtl/qdivide_seq.sv
// Sequential signed-magnitude Q15.16 divider: one restoring quotient bit per
// cycle behind a start/ready/done handshake, with saturation and /0 flags.
module qdivide_seq
    import qfix_pkg::*;
#(
    parameter int unsigned WIDTH = QW,
    parameter int unsigned FRAC  = QFRAC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             div_zero
);

    localparam int unsigned ITER = WIDTH - 1 + FRAC;
    localparam int unsigned MAGW = WIDTH - 1;
    localparam int unsigned CNTW = $clog2(ITER + 1);
    localparam int unsigned SIGN = (WIDTH == QW) ? QSIGN : WIDTH - 1;
    localparam logic [MAGW-1:0] MAG_SAT = (WIDTH == QW) ? MAGW'(QMAG_MAX) : {MAGW{1'b1}};

    qstate_e         state;
    qstate_e         state_next;

    logic            sign;
    logic [MAGW-1:0] mag_d;
    logic [ITER-1:0] num;
    logic [MAGW:0]   rem;
    logic [ITER-1:0] quot;
    logic [CNTW-1:0] cnt;

    logic [MAGW:0]   rem_step;
    logic            qbit;
    logic [ITER-1:0] quot_step;
    logic            last_step;
    logic            sat;
    logic            zero_in;

    udiv_step #(
        .MAGW (MAGW)
    ) u_step (
        .rem      (rem),
        .num_bit  (num[ITER-1]),
        .mag_d    (mag_d),
        .rem_next (rem_step),
        .qbit     (qbit)
    );

    always_comb begin
        quot_step = {quot[ITER-2:0], qbit};
        last_step = (cnt == CNTW'(1));
        sat       = |quot_step[ITER-1:MAGW];
        zero_in   = (divisor[MAGW-1:0] == '0);
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start) state_next = zero_in ? ST_DONE : ST_RUN;
            ST_RUN:  if (last_step) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // State register with handshake outputs decoded from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            ready <= (state_next == ST_IDLE);
            done  <= (state_next == ST_DONE);
        end
    end

    // Operand latch, shift/subtract datapath and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sign     <= 1'b0;
            mag_d    <= '0;
            num      <= '0;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        sign  <= dividend[SIGN] ^ divisor[SIGN];
                        mag_d <= divisor[MAGW-1:0];
                        num   <= {dividend[MAGW-1:0], {FRAC{1'b0}}};
                        rem   <= '0;
                        quot  <= '0;
                        cnt   <= CNTW'(ITER);
                        if (zero_in) begin
                            result   <= {dividend[SIGN] ^ divisor[SIGN], MAG_SAT};
                            overflow <= 1'b0;
                            div_zero <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    num  <= {num[ITER-2:0], 1'b0};
                    rem  <= rem_step;
                    quot <= quot_step;
                    cnt  <= cnt - CNTW'(1);
                    if (last_step) begin
                        result   <= {sign, sat ? MAG_SAT : quot_step[MAGW-1:0]};
                        overflow <= sat;
                        div_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_qdivide_seq.sv
// Self-checking bench for qdivide_seq: arithmetic reference model with a
// latency tracker, per-cycle output comparison, directed and random operations.
module tb_qdivide_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        overflow;
    logic        div_zero;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    qdivide_seq dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .ready    (ready),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .div_zero (div_zero)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Reference quotient from plain arithmetic: {div_zero, overflow, result}.
    function automatic logic [33:0] model_div(input logic [31:0] a, input logic [31:0] b);
        logic        s;
        logic [63:0] n;
        logic [63:0] q;
        s = a[31] ^ b[31];
        if (b[30:0] == 31'd0) return {1'b1, 1'b0, s, 31'h7FFFFFFF};
        n = {33'd0, a[30:0]} << 16;
        q = n / {33'd0, b[30:0]};
        if (q > 64'h7FFFFFFF) return {1'b0, 1'b1, s, 31'h7FFFFFFF};
        return {2'b00, s, q[30:0]};
    endfunction

    // Cycle-level expectation: idle, waiting out the fixed latency, or done.
    logic        m_ready = 1'b1;
    logic        m_done = 1'b0;
    logic [31:0] m_res = '0;
    logic        m_ov = 1'b0;
    logic        m_dz = 1'b0;
    logic [33:0] m_pend = '0;
    int          m_wait = 0;
    logic        live = 1'b0;

    always @(posedge clk) begin
        live <= 1'b1;
        if (rst) begin
            m_ready <= 1'b1;
            m_done  <= 1'b0;
            m_res   <= '0;
            m_ov    <= 1'b0;
            m_dz    <= 1'b0;
            m_wait  <= 0;
        end else if (m_done) begin
            m_done  <= 1'b0;
            m_ready <= 1'b1;
        end else if (m_wait != 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_done <= 1'b1;
                {m_dz, m_ov, m_res} <= m_pend;
            end
        end else if (m_ready && start) begin
            m_ready <= 1'b0;
            if (divisor[30:0] == 31'd0) begin
                m_done <= 1'b1;
                {m_dz, m_ov, m_res} <= model_div(dividend, divisor);
            end else begin
                m_wait <= 47;
                m_pend <= model_div(dividend, divisor);
            end
        end
    end

    always @(negedge clk) begin
        if (live) begin
            chk("cyc_ready", ready, m_ready);
            chk("cyc_done", done, m_done);
            chk("cyc_result", result, m_res);
            chk("cyc_overflow", overflow, m_ov);
            chk("cyc_div_zero", div_zero, m_dz);
        end
    end

    // Issue one operation; optionally pulse a spurious start at busy cycle spur.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int spur,
                          output logic [31:0] res, output logic ov, output logic dz,
                          output int lat);
        int w;
        w = 0;
        while (!ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!ready) chk("ready_timeout", 64'd0, 64'd1);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 200) begin
            start = (lat == spur);
            if (lat == spur) begin
                dividend = $urandom;
                divisor  = $urandom;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (!done) chk("done_timeout", 64'd0, 64'd1);
        res = result;
        ov  = overflow;
        dz  = div_zero;
    endtask

    task automatic directed(input string name, input logic [31:0] a, input logic [31:0] b,
                            input int spur, input logic [31:0] exp_res,
                            input logic exp_ov, input logic exp_dz, input int exp_lat);
        logic [31:0] res;
        logic        ov;
        logic        dz;
        int          lat;
        run_op(a, b, spur, res, ov, dz, lat);
        chk({name, "_result"}, res, exp_res);
        chk({name, "_overflow"}, ov, exp_ov);
        chk({name, "_div_zero"}, dz, exp_dz);
        chk({name, "_latency"}, lat, exp_lat);
    endtask

    function automatic logic [31:0] rnd_word(input int zero_odds);
        logic [30:0] mag;
        mag = 31'($urandom) >> $urandom_range(0, 30);
        if (zero_odds != 0 && $urandom_range(0, zero_odds - 1) == 0) mag = '0;
        return {1'($urandom_range(0, 1)), mag};
    endfunction

    initial begin
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        ov;
        logic        dz;
        int          lat;
        logic [33:0] exp;

        // Hand-computed values that pin the reference model.
        chk("model_3_div_2",    model_div(32'h00030000, 32'h00020000), {2'b00, 32'h00018000});
        chk("model_neg_frac",   model_div(32'h80018000, 32'h00008000), {2'b00, 32'h80030000});
        chk("model_third",      model_div(32'h00010000, 32'h00030000), {2'b00, 32'h00005555});
        chk("model_lsb",        model_div(32'h00000001, 32'h00010000), {2'b00, 32'h00000001});
        chk("model_div_zero",   model_div(32'h00010000, 32'h80000000), {2'b10, 32'hFFFFFFFF});
        chk("model_sat_pos",    model_div(32'h40000000, 32'h00000100), {2'b01, 32'h7FFFFFFF});
        chk("model_sat_neg",    model_div(32'hC0000000, 32'h00000100), {2'b01, 32'hFFFFFFFF});

        repeat (3) @(negedge clk);
        chk("reset_ready", ready, 1'b1);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_flags", {overflow, div_zero}, 2'b00);
        rst = 1'b0;
        @(negedge clk);

        directed("three_half", 32'h00030000, 32'h00020000, 0, 32'h00018000, 1'b0, 1'b0, 48);
        directed("neg_frac",   32'h80018000, 32'h00008000, 0, 32'h80030000, 1'b0, 1'b0, 48);
        directed("third",      32'h00010000, 32'h00030000, 0, 32'h00005555, 1'b0, 1'b0, 48);
        directed("lsb",        32'h00000001, 32'h00010000, 0, 32'h00000001, 1'b0, 1'b0, 48);
        directed("div_zero",   32'h00010000, 32'h80000000, 0, 32'hFFFFFFFF, 1'b0, 1'b1, 1);
        directed("sat_pos",    32'h40000000, 32'h00000100, 0, 32'h7FFFFFFF, 1'b1, 1'b0, 48);
        directed("sat_neg",    32'hC0000000, 32'h00000100, 0, 32'hFFFFFFFF, 1'b1, 1'b0, 48);
        directed("busy_start", 32'h00030000, 32'h00020000, 10, 32'h00018000, 1'b0, 1'b0, 48);
        directed("zero_b2b",   32'h80000000, 32'h00000000, 0, 32'hFFFFFFFF, 1'b0, 1'b1, 1);

        // Reset in the middle of a run: outputs return to reset values, no done.
        dividend = 32'h00030000;
        divisor  = 32'h00020000;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrun_ready", ready, 1'b1);
        chk("midrun_done", done, 1'b0);
        chk("midrun_result", result, 32'h0);
        chk("midrun_flags", {overflow, div_zero}, 2'b00);
        rst = 1'b0;
        @(negedge clk);
        directed("after_reset", 32'h00010000, 32'h00030000, 0, 32'h00005555, 1'b0, 1'b0, 48);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            a = rnd_word(0);
            b = rnd_word(8);
            exp = model_div(a, b);
            run_op(a, b, int'($urandom_range(0, 46)), res, ov, dz, lat);
            chk("rand_result", res, exp[31:0]);
            chk("rand_flags", {dz, ov}, exp[33:32]);
            chk("rand_latency", lat, (b[30:0] == 31'd0) ? 1 : 48);
        end

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/qdivide_seq.md
Name: qdivide_seq

Overview:
- Sequential signed-magnitude fixed-point divider for the Q15.16 word format: bit 31 is the sign, bits 30:0 are the magnitude, and the low 16 bits are fractional.
- It is the inverse of the existing combinational fixed-point multiplier and uses the same word format and sign rule.
- It sits beside that multiplier in the basic arithmetic library and is used by datapaths that can tolerate multi-cycle latency in exchange for low area.
- It uses a start/ready/done handshake and computes one quotient bit per cycle.

Parameters:
- WIDTH, 32: total word width, including the sign bit.
- FRAC, 16: number of fractional bits.
- ITER, WIDTH-1+FRAC (47): number of iterations, one per quotient bit. Derived; do not override.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active high.
- start  input  1  request pulse; sampled only while ready=1.
- dividend  input  WIDTH  signed-magnitude numerator; latched when start is accepted.
- divisor  input  WIDTH  signed-magnitude denominator; latched when start is accepted.
- ready  output  1  high in IDLE; the block can accept start.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle on.
- result  output  WIDTH  signed-magnitude quotient; held until the next accepted start.
- overflow  output  1  quotient magnitude saturated; held with result.
- div_zero  output  1  divisor magnitude was zero; held with result.

Behaviour:
- Reset values: ready=1, done=0, result=0, overflow=0, div_zero=0, state=IDLE, internal registers=0.
- A reset in any state, including mid-RUN, aborts the operation and restores the reset values on the next edge. No done pulse is produced.
- States: IDLE, RUN, DONE.
- IDLE:
  - On start=1, latch sign = dividend[31] XOR divisor[31], mag_d = divisor[30:0], and num = {dividend[30:0], FRAC zeros} (47 bits).
  - Clear the remainder and quotient, and set cnt=ITER.
  - If mag_d==0, go to DONE with result={sign, 31'h7FFFFFFF} and div_zero=1.
  - Otherwise go to RUN.
  - ready=0 from the cycle after acceptance.
- RUN, restoring algorithm, one step per cycle:
  - rem = {rem[30:0], num MSB}, 32 bits wide; shift num left.
  - If rem >= {1'b0, mag_d}, then rem -= mag_d and qbit=1; otherwise qbit=0.
  - Shift qbit into the 47-bit quotient and decrement cnt.
  - After the step where cnt reaches 0, go to DONE.
- Result update:
  - Takes effect on the edge entering DONE from RUN.
  - If quotient[46:31] != 0: magnitude = 31'h7FFFFFFF and overflow=1.
  - Otherwise: magnitude = quotient[30:0] and overflow=0.
  - The quotient is truncated toward zero; there is no rounding.
  - div_zero=0 on this path.
- Sign rule: sign = XOR of the input signs, including when the magnitude is 0. This matches the multiplier, so a negative zero is possible.
- DONE: done=1 for exactly one cycle, then IDLE unconditionally. start is ignored in DONE.
- Latency, counting the start-accept edge as cycle 0:
  - Normal: done is high in cycle ITER+1 (48).
  - Divide-by-zero: done is high in cycle 1.
  - Minimum start-to-start spacing is 49 cycles (normal) and 2 cycles (divide-by-zero).
- start while ready=0 is ignored. The operands are not re-sampled.
- Input changes after acceptance have no effect.
- result, overflow and div_zero are only updated on the edge entering DONE and on reset.

Decomposition:
- Shared package qfix_pkg holds:
  - QW=32 and QFRAC=16.
  - QSIGN=31.
  - QMAG_MAX=31'h7FFFFFFF.
  - The state encoding for IDLE, RUN and DONE.
- The multiplier and divider both use the package.
- One natural sub-module: udiv_step, a combinational single restoring step. Inputs are rem, the next num bit and mag_d; outputs are next rem and qbit. The top module owns the FSM, the counter, the shift registers and saturation.

Test Plan:
- 3.0/2.0: dividend 0x00030000, divisor 0x00020000 -> result 0x00018000, overflow=0, div_zero=0, done exactly 48 cycles after acceptance.
- Sign and fraction: 0x80018000 (-1.5) / 0x00008000 (0.5) -> 0x80030000 (-3.0).
- Truncation and LSB: 0x00010000 / 0x00030000 -> 0x00005555; 0x00000001 / 0x00010000 -> 0x00000001.
- Divide-by-zero: 0x00010000 / 0x80000000 -> 0xFFFFFFFF, div_zero=1, done 1 cycle after acceptance.
- Saturation: 0x40000000 / 0x00000100 -> 0x7FFFFFFF, overflow=1; 0xC0000000 / 0x00000100 -> 0xFFFFFFFF, overflow=1.
- Handshake and reset:
  - Pulse start with new operands at cycle 10 of a busy run -> ignored; the first result is unchanged.
  - Assert rst at cycle 20 of a run -> no done, all outputs 0, ready=1 the next cycle.
  - A new start afterwards completes normally.
